// File: rtl/reg_scoreboard_file_pkg.sv
// reg_scoreboard_file_pkg: register ids, value layout and helpers shared by the register file and scoreboard
package reg_scoreboard_file_pkg;
  localparam int REG_FILE_SIZE = 20;
  localparam int SB_CNT_W = 2;
  localparam int RF_NUM_RD = 4;
  localparam int RF_NUM_WR = 2;
  typedef logic [7:0] reg_id_t;
  localparam reg_id_t RAX = 8'd0, RCX = 8'd1, RDX = 8'd2, RBX = 8'd3, RSP = 8'd4, RBP = 8'd5;
  localparam reg_id_t RSI = 8'd6, RDI = 8'd7, R8 = 8'd8, R9 = 8'd9, R10 = 8'd10, R11 = 8'd11;
  localparam reg_id_t R12 = 8'd12, R13 = 8'd13, R14 = 8'd14, R15 = 8'd15, RFLAGS = 8'd16;
  localparam reg_id_t RTA = 8'd17, RTB = 8'd18, RHC = 8'd19;
  localparam reg_id_t RNIL = 8'h20, RIP = 8'h21, RIMM = 8'h22, RV0 = 8'h23, RV8 = 8'h24;
  typedef struct packed {
    logic cf, zf, sf, of, pf, af;
  } flags_t;
  typedef struct packed {
    flags_t flags;
    logic [63:0] val;
  } reg_val_t;
  function automatic logic reg_in_file(reg_id_t id);
    return id < 8'(REG_FILE_SIZE);
  endfunction
  function automatic logic [4:0] reg_num(reg_id_t id);
    return 5'(id);
  endfunction
  function automatic reg_val_t const_val(reg_id_t id);
    return (id == RV8) ? reg_val_t'(70'd8) : reg_val_t'('0);
  endfunction
endpackage

// File: rtl/reg_scoreboard_file_if.sv
// reg_scoreboard_file_if: read, claim and writeback bundle between the pipeline and the register file
interface reg_scoreboard_file_if import reg_scoreboard_file_pkg::*; ();
  reg_id_t [RF_NUM_RD-1:0] rd_id;
  reg_val_t [RF_NUM_RD-1:0] rd_val;
  logic [RF_NUM_RD-1:0] rd_busy;
  logic claim_vld;
  reg_id_t claim_id;
  logic claim_ok;
  logic [RF_NUM_WR-1:0] wr_vld;
  reg_id_t [RF_NUM_WR-1:0] wr_id;
  reg_val_t [RF_NUM_WR-1:0] wr_val;
  logic [RF_NUM_WR-1:0] wr_setf;
  logic flush;
  logic err;
  modport master(output rd_id, claim_vld, claim_id, wr_vld, wr_id, wr_val, wr_setf, flush,
                 input rd_val, rd_busy, claim_ok, err);
  modport slave(input rd_id, claim_vld, claim_id, wr_vld, wr_id, wr_val, wr_setf, flush,
                output rd_val, rd_busy, claim_ok, err);
endinterface

// File: rtl/reg_sb_cnt.sv
// reg_sb_cnt: outstanding-claim counter for one register, floored on release and cleared by flush
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic flush,
  input  logic [1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_wr
);
  assign cnt_wr = (CNT_W'(dec) >= cnt) ? '0 : cnt - CNT_W'(dec);
  always_ff @(posedge clk) cnt <= (rst || flush) ? '0 : cnt_wr + CNT_W'(inc);
endmodule

// File: rtl/reg_scoreboard_file.sv
// reg_scoreboard_file: multi-port architectural register file with write-first bypass and per-register busy scoreboard
module reg_scoreboard_file import reg_scoreboard_file_pkg::*; #(
  parameter int NUM_REGS = REG_FILE_SIZE,
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR,
  parameter int CNT_W = SB_CNT_W
) (
  input logic clk,
  input logic reset,
  reg_scoreboard_file_if.slave bus
);
  localparam logic [4:0] FLAGS_N = reg_num(RFLAGS);
  reg_val_t data [NUM_REGS];
  reg_val_t d_nxt [NUM_REGS];
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] cnt_wr [NUM_REGS];
  logic [1:0] dec [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_WR-1:0] legal;
  // Ascending port order lets the higher index win both data and rflags merges.
  always_comb begin
    d_nxt = data;
    legal = '0;
    for (int r = 0; r < NUM_REGS; r++) dec[r] = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      legal[p] = bus.wr_vld[p] && reg_in_file(bus.wr_id[p]) && cnt[reg_num(bus.wr_id[p])] != '0;
      if (legal[p]) begin
        d_nxt[reg_num(bus.wr_id[p])] = bus.wr_val[p];
        dec[reg_num(bus.wr_id[p])] = dec[reg_num(bus.wr_id[p])] + 2'd1;
        if (bus.wr_setf[p] && bus.wr_id[p] != RFLAGS) d_nxt[FLAGS_N].flags = bus.wr_val[p].flags;
      end
    end
  end
  // Claims see the post-writeback count so a release frees a slot in the same cycle.
  always_comb begin
    bus.claim_ok = bus.claim_vld && !bus.flush &&
                   (!reg_in_file(bus.claim_id) || cnt_wr[reg_num(bus.claim_id)] != '1);
    inc = '0;
    if (bus.claim_ok && reg_in_file(bus.claim_id)) inc[reg_num(bus.claim_id)] = 1'b1;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_val[i] = reg_in_file(bus.rd_id[i]) ? d_nxt[reg_num(bus.rd_id[i])] : const_val(bus.rd_id[i]);
      bus.rd_busy[i] = reg_in_file(bus.rd_id[i]) && cnt_wr[reg_num(bus.rd_id[i])] != '0;
    end
  end
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(reset),
      .inc(inc[r]),
      .flush(bus.flush),
      .dec(dec[r]),
      .cnt(cnt[r]),
      .cnt_wr(cnt_wr[r])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) data <= '{default: '0};
    else data <= d_nxt;
    bus.err <= !reset && |(bus.wr_vld & ~legal);
  end
endmodule

// File: tb/tb_reg_scoreboard_file.sv
// tb_reg_scoreboard_file: directed scenarios plus randomized traffic against a behavioural register/scoreboard model
module tb_reg_scoreboard_file;
  import reg_scoreboard_file_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  reg_scoreboard_file_if bus();
  reg_scoreboard_file dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  reg_val_t m_val [20];
  int m_cnt [20];
  bit m_err;
  reg_val_t n_val [20];
  int n_cnt [20];
  bit n_err;
  reg_val_t e_rd [RF_NUM_RD];
  bit e_busy [RF_NUM_RD];
  bit e_ok;

  function automatic reg_val_t mk(logic [5:0] f, logic [63:0] v);
    return {f, v};
  endfunction

  function automatic reg_id_t rnd_id();
    int r = $urandom_range(0, 9);
    if (r == 0) return reg_id_t'(8'h20 + 8'($urandom_range(0, 4)));
    if (r < 6) return reg_id_t'($urandom_range(0, 3));
    return reg_id_t'($urandom_range(0, 19));
  endfunction

  task automatic idle();
    for (int i = 0; i < RF_NUM_RD; i++) bus.rd_id[i] = RAX;
    bus.claim_vld = 1'b0;
    bus.claim_id = RAX;
    bus.wr_vld = '0;
    bus.wr_setf = '0;
    bus.flush = 1'b0;
    for (int p = 0; p < RF_NUM_WR; p++) begin
      bus.wr_id[p] = RAX;
      bus.wr_val[p] = '0;
    end
  endtask

  // Model: writes land in port order if the register has a pending claim; releases count per write.
  task automatic predict();
    int w [20];
    int cid;
    n_val = m_val;
    n_err = 0;
    for (int r = 0; r < 20; r++) w[r] = 0;
    for (int p = 0; p < RF_NUM_WR; p++) begin
      if (bus.wr_vld[p]) begin
        int id = int'(bus.wr_id[p]);
        if (id < 20 && m_cnt[id] > 0) begin
          n_val[id] = bus.wr_val[p];
          if (bus.wr_setf[p] && id != 16) n_val[16].flags = bus.wr_val[p].flags;
          w[id]++;
        end else n_err = 1;
      end
    end
    for (int r = 0; r < 20; r++) n_cnt[r] = (m_cnt[r] > w[r]) ? m_cnt[r] - w[r] : 0;
    cid = int'(bus.claim_id);
    e_ok = bus.claim_vld && !bus.flush && ((cid >= 20) ? 1'b1 : (n_cnt[cid] < 3));
    for (int i = 0; i < RF_NUM_RD; i++) begin
      int rid = int'(bus.rd_id[i]);
      e_rd[i] = (rid < 20) ? n_val[rid] : ((rid == int'(RV8)) ? mk(6'h0, 64'd8) : mk(6'h0, 64'd0));
      e_busy[i] = (rid < 20) ? (n_cnt[rid] > 0) : 1'b0;
    end
    if (e_ok && cid < 20) n_cnt[cid]++;
    if (bus.flush) for (int r = 0; r < 20; r++) n_cnt[r] = 0;
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 20; r++) begin
        m_val[r] = '0;
        m_cnt[r] = 0;
      end
      m_err = 0;
    end else begin
      m_val = n_val;
      m_cnt = n_cnt;
      m_err = n_err;
    end
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    bus.rd_id[0] = RAX;
    bus.rd_id[1] = RV8;
    bus.rd_id[2] = RNIL;
    bus.rd_id[3] = RFLAGS;
    #1;
    checks++; if (bus.rd_val[0] !== mk(6'h0, 64'd0)) begin errors++; $display("FAIL reset_rax got=%h exp=0", bus.rd_val[0]); end
    checks++; if (bus.rd_val[1] !== mk(6'h0, 64'd8)) begin errors++; $display("FAIL reset_rv8 got=%h exp=8", bus.rd_val[1]); end
    checks++; if (bus.rd_val[2] !== mk(6'h0, 64'd0)) begin errors++; $display("FAIL reset_rnil got=%h exp=0", bus.rd_val[2]); end
    checks++; if (bus.rd_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got=%b exp=0000", bus.rd_busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_claim_write();
    idle();
    bus.claim_vld = 1'b1;
    bus.claim_id = RBX;
    #1;
    checks++; if (bus.claim_ok !== 1'b1) begin errors++; $display("FAIL claim_rbx_ok got=%b exp=1", bus.claim_ok); end
    tick();
    idle();
    bus.rd_id[0] = RBX;
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rbx_busy got=%b exp=1", bus.rd_busy[0]); end
    bus.wr_vld = 2'b01;
    bus.wr_id[0] = RBX;
    bus.wr_val[0] = mk(6'h0, 64'h1234);
    #1;
    checks++; if (bus.rd_val[0] !== mk(6'h0, 64'h1234)) begin errors++; $display("FAIL rbx_bypass got=%h exp=1234", bus.rd_val[0]); end
    tick();
    idle();
    bus.rd_id[0] = RBX;
    #1;
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL rbx_released got=%b exp=0", bus.rd_busy[0]); end
    checks++; if (bus.rd_val[0] !== mk(6'h0, 64'h1234)) begin errors++; $display("FAIL rbx_stored got=%h exp=1234", bus.rd_val[0]); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 4; k++) begin
      idle();
      bus.claim_vld = 1'b1;
      bus.claim_id = RCX;
      #1;
      checks++; if (bus.claim_ok !== (k < 3)) begin errors++; $display("FAIL sat_claim%0d got=%b exp=%b", k, bus.claim_ok, k < 3); end
      tick();
    end
    bus.wr_vld = 2'b01;
    bus.wr_id[0] = RCX;
    bus.wr_val[0] = mk(6'h0, 64'hc0de);
    #1;
    checks++; if (bus.claim_ok !== 1'b1) begin errors++; $display("FAIL sat_claim_with_write got=%b exp=1", bus.claim_ok); end
    tick();
    idle();
    bus.claim_vld = 1'b1;
    bus.claim_id = RCX;
    bus.rd_id[0] = RCX;
    #1;
    checks++; if (bus.claim_ok !== 1'b0) begin errors++; $display("FAIL sat_still_full got=%b exp=0", bus.claim_ok); end
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sat_busy got=%b exp=1", bus.rd_busy[0]); end
    tick();
  endtask

  task automatic test_illegal();
    idle();
    bus.wr_vld = 2'b01;
    bus.wr_id[0] = RDX;
    bus.wr_val[0] = mk(6'h3f, 64'h55);
    bus.rd_id[0] = RDX;
    #1;
    checks++; if (bus.rd_val[0] !== mk(6'h0, 64'd0)) begin errors++; $display("FAIL illegal_no_bypass got=%h exp=0", bus.rd_val[0]); end
    tick();
    idle();
    bus.rd_id[0] = RDX;
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", bus.err); end
    checks++; if (bus.rd_val[0] !== mk(6'h0, 64'd0)) begin errors++; $display("FAIL illegal_dropped got=%h exp=0", bus.rd_val[0]); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got=%b exp=0", bus.err); end
    bus.wr_vld = 2'b10;
    bus.wr_id[1] = RIMM;
    bus.wr_val[1] = mk(6'h0, 64'h77);
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_rimm_err got=%b exp=1", bus.err); end
    idle();
    tick();
  endtask

  task automatic test_setf();
    for (int k = 0; k < 2; k++) begin
      idle();
      bus.claim_vld = 1'b1;
      bus.claim_id = RAX;
      tick();
    end
    idle();
    bus.wr_vld = 2'b11;
    bus.wr_id[0] = RAX;
    bus.wr_id[1] = RAX;
    bus.wr_val[0] = mk(6'h0, 64'd5);
    bus.wr_val[1] = mk(6'b010000, 64'd9);
    bus.wr_setf = 2'b10;
    bus.rd_id[0] = RAX;
    bus.rd_id[1] = RFLAGS;
    #1;
    checks++; if (bus.rd_val[0] !== mk(6'b010000, 64'd9)) begin errors++; $display("FAIL setf_bypass_rax got=%h exp=9", bus.rd_val[0]); end
    checks++; if (bus.rd_val[1].flags.zf !== 1'b1) begin errors++; $display("FAIL setf_bypass_zf got=%b exp=1", bus.rd_val[1].flags.zf); end
    tick();
    idle();
    bus.rd_id[0] = RAX;
    bus.rd_id[1] = RFLAGS;
    #1;
    checks++; if (bus.rd_val[0].val !== 64'd9) begin errors++; $display("FAIL setf_rax got=%h exp=9", bus.rd_val[0].val); end
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL setf_rax_busy got=%b exp=0", bus.rd_busy[0]); end
    checks++; if (bus.rd_val[1] !== mk(6'b010000, 64'd0)) begin errors++; $display("FAIL setf_rflags got=%h exp=%h", bus.rd_val[1], mk(6'b010000, 64'd0)); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL setf_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_flush();
    idle();
    bus.claim_vld = 1'b1;
    bus.claim_id = R8;
    tick();
    bus.claim_id = R9;
    tick();
    idle();
    bus.flush = 1'b1;
    bus.wr_vld = 2'b01;
    bus.wr_id[0] = R8;
    bus.wr_val[0] = mk(6'h0, 64'd7);
    bus.claim_vld = 1'b1;
    bus.claim_id = R10;
    #1;
    checks++; if (bus.claim_ok !== 1'b0) begin errors++; $display("FAIL flush_claim_ok got=%b exp=0", bus.claim_ok); end
    tick();
    idle();
    bus.rd_id[0] = R8;
    bus.rd_id[1] = R9;
    bus.rd_id[2] = R10;
    #1;
    checks++; if (bus.rd_val[0] !== mk(6'h0, 64'd7)) begin errors++; $display("FAIL flush_r8 got=%h exp=7", bus.rd_val[0]); end
    checks++; if (bus.rd_busy[2:0] !== 3'b000) begin errors++; $display("FAIL flush_busy got=%b exp=000", bus.rd_busy[2:0]); end
    bus.claim_vld = 1'b1;
    bus.claim_id = R11;
    tick();
    bus.claim_id = R12;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    bus.rd_id[0] = RBX;
    bus.rd_id[1] = RFLAGS;
    bus.rd_id[2] = R8;
    bus.rd_id[3] = R11;
    #1;
    checks++; if (bus.rd_val[0] !== '0 || bus.rd_val[1] !== '0 || bus.rd_val[2] !== '0)
      begin errors++; $display("FAIL reset_mid_vals got=%h,%h,%h exp=0", bus.rd_val[0], bus.rd_val[1], bus.rd_val[2]); end
    checks++; if (bus.rd_busy !== 4'b0000) begin errors++; $display("FAIL reset_mid_busy got=%b exp=0000", bus.rd_busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.claim_vld = ($urandom_range(0, 9) < 6);
      bus.claim_id = rnd_id();
      for (int p = 0; p < RF_NUM_WR; p++) begin
        bus.wr_vld[p] = $urandom_range(0, 1);
        bus.wr_id[p] = rnd_id();
        bus.wr_val[p] = mk(6'($urandom), {$urandom, $urandom});
        bus.wr_setf[p] = $urandom_range(0, 1);
      end
      bus.rd_id[0] = bus.wr_id[0];
      bus.rd_id[1] = bus.wr_id[1];
      bus.rd_id[2] = RFLAGS;
      bus.rd_id[3] = rnd_id();
      #1;
      predict();
      for (int i = 0; i < RF_NUM_RD; i++) begin
        checks++; if (bus.rd_val[i] !== e_rd[i]) begin errors++; $display("FAIL rnd_rd_val%0d cyc%0d got=%h exp=%h", i, n, bus.rd_val[i], e_rd[i]); end
        checks++; if (bus.rd_busy[i] !== e_busy[i]) begin errors++; $display("FAIL rnd_rd_busy%0d cyc%0d got=%b exp=%b", i, n, bus.rd_busy[i], e_busy[i]); end
      end
      checks++; if (bus.claim_ok !== e_ok) begin errors++; $display("FAIL rnd_claim_ok cyc%0d got=%b exp=%b", n, bus.claim_ok, e_ok); end
      tick();
      checks++; if (bus.err !== m_err) begin errors++; $display("FAIL rnd_err cyc%0d got=%b exp=%b", n, bus.err, m_err); end
    end
    reset = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_claim_write();
    test_saturate();
    test_illegal();
    test_setf();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
